// File: rtl/ps2_key_sequencer.sv
// PS/2 set-2 byte-stream parser: turns raw receiver bytes into key events,
// queues them in a first-word-fall-through FIFO and aborts stalled prefixes.
module ps2_key_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic       FPGA_clock,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] last_code,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       timeout
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_ONE   = WDW'(1);
  localparam logic [WDW-1:0] WD_ZERO  = WDW'(0);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW-1:0]  PTR_ZERO = AW'(0);
  localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]    CNT_ZERO = (AW + 1)'(0);
  localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } state_t;

  // Controller responses and line-noise bytes that never form a key event.
  function automatic logic is_resp(input logic [7:0] b);
    is_resp = (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
              (b == 8'h00) || (b == 8'hFF);
  endfunction

  logic           r_dv_q;
  state_t         r_state;
  logic [WDW-1:0] r_wd;
  logic           r_timeout;

  logic [9:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_ev_valid;
  logic [7:0]     r_ev_code;
  logic           r_ev_ext;
  logic           r_ev_break;
  logic [7:0]     r_last_code;
  logic           r_overflow;

  logic           w_byte_stb;
  state_t         w_state_nxt;
  logic           w_push_req;
  logic           w_ev_ext;
  logic           w_ev_brk;
  logic           w_tmo;
  logic [9:0]     w_entry;
  logic           w_pop;
  logic           w_full;
  logic           w_push;
  logic           w_drop;
  logic [AW:0]    w_cnt_after_pop;
  logic [AW:0]    w_cnt_nxt;
  logic [AW-1:0]  w_rd_nxt;
  logic [AW-1:0]  w_wr_nxt;
  logic [9:0]     w_head_nxt;

  assign w_byte_stb = data_valid & ~r_dv_q;

  // A byte landing on the last watchdog cycle is processed normally and
  // suppresses the abort, so the strobe branch is evaluated first.
  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    w_ev_ext    = 1'b0;
    w_ev_brk    = 1'b0;
    w_tmo       = 1'b0;
    if (w_byte_stb) begin
      if (is_resp(data_in)) begin
        w_state_nxt = ST_IDLE;
      end else if (data_in == 8'hE0) begin
        w_state_nxt = ST_E0;
      end else if (data_in == 8'hF0) begin
        case (r_state)
          ST_IDLE: w_state_nxt = ST_F0;
          ST_E0:   w_state_nxt = ST_E0F0;
          ST_F0:   w_state_nxt = ST_F0;
          ST_E0F0: w_state_nxt = ST_E0F0;
          default: w_state_nxt = ST_IDLE;
        endcase
      end else begin
        w_push_req  = 1'b1;
        w_state_nxt = ST_IDLE;
        case (r_state)
          ST_IDLE: begin w_ev_ext = 1'b0; w_ev_brk = 1'b0; end
          ST_E0:   begin w_ev_ext = 1'b1; w_ev_brk = 1'b0; end
          ST_F0:   begin w_ev_ext = 1'b0; w_ev_brk = 1'b1; end
          ST_E0F0: begin w_ev_ext = 1'b1; w_ev_brk = 1'b1; end
          default: begin w_ev_ext = 1'b0; w_ev_brk = 1'b0; end
        endcase
      end
    end else if ((r_state != ST_IDLE) && (r_wd == WD_LAST)) begin
      w_state_nxt = ST_IDLE;
      w_tmo       = 1'b1;
    end else begin
      w_state_nxt = r_state;
    end
  end

  always_ff @(posedge FPGA_clock or negedge rst) begin
    if (!rst) begin
      r_dv_q    <= 1'b0;
      r_state   <= ST_IDLE;
      r_wd      <= WD_ZERO;
      r_timeout <= 1'b0;
    end else begin
      r_dv_q    <= data_valid;
      r_state   <= w_state_nxt;
      r_timeout <= w_tmo;
      if (w_byte_stb || (r_state == ST_IDLE) || w_tmo) begin
        r_wd <= WD_ZERO;
      end else begin
        r_wd <= r_wd + WD_ONE;
      end
    end
  end

  assign w_entry         = {w_ev_ext, w_ev_brk, data_in};
  assign w_pop           = r_ev_valid & ev_ready;
  assign w_full          = (r_count == CNT_FULL);
  assign w_push          = w_push_req & (~w_full | w_pop);
  assign w_drop          = w_push_req & w_full & ~w_pop;
  assign w_cnt_after_pop = w_pop  ? (r_count - CNT_ONE) : r_count;
  assign w_cnt_nxt       = w_push ? (w_cnt_after_pop + CNT_ONE) : w_cnt_after_pop;
  assign w_rd_nxt        = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
  assign w_wr_nxt        = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;

  // Head register: an entry pushed into an (effectively) empty queue bypasses
  // the memory so it is visible one cycle after its strobe.
  always_comb begin
    w_head_nxt = {r_ev_ext, r_ev_break, r_ev_code};
    if (w_cnt_nxt == CNT_ZERO) begin
      w_head_nxt = {r_ev_ext, r_ev_break, r_ev_code};
    end else if (w_cnt_after_pop == CNT_ZERO) begin
      w_head_nxt = w_entry;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge FPGA_clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 10'd0;
      end
      r_wr_ptr   <= PTR_ZERO;
      r_rd_ptr   <= PTR_ZERO;
      r_count    <= CNT_ZERO;
      r_ev_valid <= 1'b0;
      r_ev_code  <= 8'h00;
      r_ev_ext   <= 1'b0;
      r_ev_break <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
      end else begin
        r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
      end
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      r_count    <= w_cnt_nxt;
      r_ev_valid <= (w_cnt_nxt != CNT_ZERO);
      r_ev_ext   <= w_head_nxt[9];
      r_ev_break <= w_head_nxt[8];
      r_ev_code  <= w_head_nxt[7:0];
    end
  end

  // last_code follows every make, even one that is dropped on overflow.
  always_ff @(posedge FPGA_clock or negedge rst) begin
    if (!rst) begin
      r_last_code <= 8'h00;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push_req && !w_ev_brk) begin
        r_last_code <= data_in;
      end else begin
        r_last_code <= r_last_code;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end else begin
        r_overflow <= r_overflow;
      end
    end
  end

  assign ev_valid  = r_ev_valid;
  assign ev_code   = r_ev_code;
  assign ev_ext    = r_ev_ext;
  assign ev_break  = r_ev_break;
  assign last_code = r_last_code;
  assign overflow  = r_overflow;
  assign timeout   = r_timeout;

endmodule
